// File: rtl/adder_result_stage.sv
// Registered result stage behind the ripple-carry adder: flag derivation plus 2-entry valid/ready FIFO.
// Optional ADDER_RESULT_STATS_EN adds saturating transaction / overflow counters.
module adder_result_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  input  logic             a_msb_i,
  input  logic             b_msb_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o
`ifdef ADDER_RESULT_STATS_EN
  ,
  output logic [15:0]      txn_cnt_o,
  output logic [15:0]      ovf_cnt_o
`endif
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned ENT_W = WIDTH + 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e             state_q;
  state_e             state_d;
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [ENT_W-1:0]   ent_q [DEPTH];
  logic               push_c;
  logic               pop_c;
  logic               ovf_c;
  logic [ENT_W-1:0]   new_ent_c;

  assign in_ready_o  = (state_q != S_FULL);
  assign out_valid_o = (state_q != S_EMPTY);
  assign push_c      = in_valid_i & in_ready_o;
  assign pop_c       = out_valid_o & out_ready_i;

  // Flags are evaluated once at capture and travel with the entry as {ovf, neg, zero, carry, sum}.
  assign ovf_c     = (a_msb_i == b_msb_i) & (sum_i[WIDTH-1] != a_msb_i);
  assign new_ent_c = {ovf_c, sum_i[WIDTH-1], ~|sum_i, cout_i, sum_i};

  assign {ovf_o, neg_o, zero_o, carry_o, result_o} = ent_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Occupancy next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (push_c) state_d = S_ONE;
      S_ONE: begin
        if (push_c && !pop_c)      state_d = S_FULL;
        else if (pop_c && !push_c) state_d = S_EMPTY;
      end
      S_FULL:  if (pop_c) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
  end

  // Storage and pointers; entries are cleared on reset so the head reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      if (push_c) begin
        ent_q[wr_ptr_q] <= new_ent_c;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef ADDER_RESULT_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_cnt_o <= 16'd0;
      ovf_cnt_o <= 16'd0;
    end else if (push_c) begin
      if (txn_cnt_o != 16'hFFFF) txn_cnt_o <= txn_cnt_o + 16'd1;
      if (ovf_c && (ovf_cnt_o != 16'hFFFF)) ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_adder_result_stage.sv
// Self-checking bench for adder_result_stage: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_adder_result_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] sum_i;
  logic        cout_i;
  logic        a_msb_i;
  logic        b_msb_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        carry_o;
  logic        zero_o;
  logic        neg_o;
  logic        ovf_o;
`ifdef ADDER_RESULT_STATS_EN
  logic [15:0] txn_cnt_o;
  logic [15:0] ovf_cnt_o;
`endif

  adder_result_stage #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sum_i       (sum_i),
    .cout_i      (cout_i),
    .a_msb_i     (a_msb_i),
    .b_msb_i     (b_msb_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .zero_o      (zero_o),
    .neg_o       (neg_o),
    .ovf_o       (ovf_o)
`ifdef ADDER_RESULT_STATS_EN
    ,
    .txn_cnt_o   (txn_cnt_o),
    .ovf_cnt_o   (ovf_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        a;
    logic        b;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;   // {carry, zero, neg, ovf}
  } vec_t;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags;
  } ent_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs [7];
  ent_t mq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {carry_o, zero_o, neg_o, ovf_o};
  endfunction

  // Reference flags straight from arithmetic on the sum and operand signs.
  function automatic logic [3:0] ref_flags(input logic [31:0] s, input logic c,
                                           input logic a, input logic b);
    logic z, n, v;
    z = (s == 32'd0);
    n = (s >= 32'h8000_0000);
    v = (a == b) && (n != a);
    return {c, z, n, v};
  endfunction

  task automatic drive(input logic v, input logic [31:0] s, input logic c,
                       input logic a, input logic b, input logic rdy);
    in_valid_i  = v;
    sum_i       = s;
    cout_i      = c;
    a_msb_i     = a;
    b_msb_i     = b;
    out_ready_i = rdy;
  endtask

  int txn_exp;
  int ovf_exp;

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b1100};
    vecs[1] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0011};
    vecs[2] = '{32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0000};
    vecs[3] = '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1001};
    vecs[4] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 4'b1010};
    vecs[5] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b0010};
    vecs[6] = '{32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 4'b1000};

    // Reset held two cycles
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_flags", 64'(dut_flags()), 64'd0);
    rst_i = 1'b0;

    // Table: one push each, visible the next cycle, gone after the pop
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].sum, vecs[i].cout, vecs[i].a, vecs[i].b, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'd1);
      chk($sformatf("vec%0d_result", i), 64'(result_o), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_flags", i), 64'(dut_flags()), 64'(vecs[i].exp_flags));
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("vec%0d_drained", i), 64'(out_valid_o), 64'd0);
    end

    // Back-pressure: fill, refuse a third, drain in order
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_full_ready", 64'(in_ready_o), 64'd0);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_hold_head", 64'(result_o), 64'h11);
    chk("bp_hold_ready", 64'(in_ready_o), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_first", 64'(result_o), 64'h11);
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_second", 64'(result_o), 64'h22);
    chk("bp_second_valid", 64'(out_valid_o), 64'd1);
    chk("bp_ready_back", 64'(in_ready_o), 64'd1);
    @(posedge clk_i); @(negedge clk_i);
    chk("bp_no_third", 64'(out_valid_o), 64'd0);

    // Streaming 1..8 at full rate
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin
        chk($sformatf("stream%0d_result", k - 1), 64'(result_o), 64'(k - 1));
        chk($sformatf("stream%0d_ready", k - 1), 64'(in_ready_o), 64'd1);
      end
      drive(1'b1, 32'(k), 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk_i); @(negedge clk_i);
    end
    chk("stream8_result", 64'(result_o), 64'd8);
    chk("stream8_ready", 64'(in_ready_o), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_i); @(negedge clk_i);
    chk("stream_empty", 64'(out_valid_o), 64'd0);

    // Reset mid-flight with the FIFO full
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    drive(1'b1, 32'h8000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    chk("mid_full", 64'(in_ready_o), 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    chk("mid_valid", 64'(out_valid_o), 64'd0);
    chk("mid_ready", 64'(in_ready_o), 64'd1);
    chk("mid_result", 64'(result_o), 64'd0);
`ifdef ADDER_RESULT_STATS_EN
    chk("mid_txn_cnt", 64'(txn_cnt_o), 64'd0);
    chk("mid_ovf_cnt", 64'(ovf_cnt_o), 64'd0);
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("mid_stays_empty", 64'(out_valid_o), 64'd0);

    // Randomized traffic against the queue model
    txn_exp = 0;
    ovf_exp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic        v, r, c, a, b, push, pop;
      logic [31:0] s;
      ent_t        e;
      chk("rnd_ready", 64'(in_ready_o), 64'(mq.size() < 2));
      chk("rnd_valid", 64'(out_valid_o), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("rnd_result", 64'(result_o), 64'(mq[0].sum));
        chk("rnd_flags", 64'(dut_flags()), 64'(mq[0].flags));
      end
      v = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 2) != 0);
      c = 1'($urandom);
      a = 1'($urandom);
      b = 1'($urandom);
      s = $urandom;
      if ($urandom_range(0, 7) == 0) s = 32'd0;
      drive(v, s, c, a, b, r);
      push = v && (mq.size() < 2);
      pop  = r && (mq.size() > 0);
      e.sum   = s;
      e.flags = ref_flags(s, c, a, b);
      @(posedge clk_i);
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        txn_exp++;
        if (e.flags[0]) ovf_exp++;
      end
      @(negedge clk_i);
    end
`ifdef ADDER_RESULT_STATS_EN
    chk("rnd_txn_cnt", 64'(txn_cnt_o), 64'(txn_exp));
    chk("rnd_ovf_cnt", 64'(ovf_cnt_o), 64'(ovf_exp));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
